// File: rtl/adder72_pkg.sv
// Shared constants, FSM state and operand bundle for the adder72 input staging stage.
package adder72_pkg;
  localparam int W     = 72;
  localparam int LANE  = 24;
  localparam int NLANE = W / LANE;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [W:1] a;
    logic [W:1] b;
    logic       c;
    logic       sub;
  } operand_t;

  // Even parity of one lane: the parity bit equals the XOR of the data bits.
  function automatic logic lane_par(input logic [LANE-1:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/adder72_skid.sv
// Generic 2-entry skid buffer; every output (including in_ready) comes straight from a flop.
module adder72_skid
  import adder72_pkg::*;
#(
  parameter type T = operand_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  state_e state_q;
  T       main_q, skid_q;
  logic   in_ready_q, out_valid_q;
  logic   acc, drn;

  assign acc = in_valid & in_ready_q;
  assign drn = out_valid_q & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: if (acc) begin
          main_q      <= in_data;
          out_valid_q <= 1'b1;
          state_q     <= ONE;
        end
        ONE: begin
          if (acc && !drn) begin
            skid_q     <= in_data;
            in_ready_q <= 1'b0;
            state_q    <= TWO;
          end else if (acc && drn) begin
            main_q <= in_data;
          end else if (drn) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        TWO: if (drn) begin
          // in_ready is low here, so the skid entry is the only candidate for main.
          main_q     <= skid_q;
          in_ready_q <= 1'b1;
          state_q    <= ONE;
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/adder72_in_stage.sv
// Operand staging ahead of the 72-bit adder: subtract transform, then a registered skid buffer.
// Define ADDER72_PARITY_EN to add per-lane even-parity checking with a sticky par_err flag.
module adder72_in_stage #(
  parameter int W    = adder72_pkg::W,
  parameter int LANE = adder72_pkg::LANE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W:1]   in_a,
  input  logic [W:1]   in_b,
  input  logic         in_sub,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:1]   A,
  output logic [W:1]   B,
  output logic         c0,
  output logic         out_sub
`ifdef ADDER72_PARITY_EN
  ,
  input  logic [W/LANE-1:0] in_par_a,
  input  logic [W/LANE-1:0] in_par_b,
  output logic              par_err
`endif
);
  import adder72_pkg::*;

  // The bundle width is fixed by the package; W must stay a whole number of lanes.
  if ((W % LANE) != 0) begin : g_w_not_lane_multiple
  end

  operand_t in_x, out_x;

  // Transform before storage so the adder sees final operands straight from flops.
  always_comb begin
    in_x     = '0;
    in_x.a   = in_a;
    in_x.b   = in_sub ? ~in_b : in_b;
    in_x.c   = in_sub | in_cin;
    in_x.sub = in_sub;
  end

  adder72_skid #(.T(operand_t)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_x),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_x)
  );

  assign A       = out_x.a;
  assign B       = out_x.b;
  assign c0      = out_x.c;
  assign out_sub = out_x.sub;

`ifdef ADDER72_PARITY_EN
  localparam int NL = W / LANE;
  logic [NL-1:0] lane_bad;
  logic          par_err_q;

  for (genvar k = 0; k < NL; k++) begin : g_lane
    assign lane_bad[k] = (lane_par(in_a[k*LANE+1 +: LANE]) != in_par_a[k]) |
                         (lane_par(in_b[k*LANE+1 +: LANE]) != in_par_b[k]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             par_err_q <= 1'b0;
    else if (in_valid && in_ready && |lane_bad) par_err_q <= 1'b1;
  end

  assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_adder72_in_stage.sv
// Self-checking bench for adder72_in_stage: FIFO-of-depth-2 reference model plus literal checks.
module tb_adder72_in_stage;
  localparam int W = 72;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, in_sub = 1'b0, in_cin = 1'b0, out_ready = 1'b0;
  logic [W:1]   in_a = '0, in_b = '0;
  logic         in_ready, out_valid, c0, out_sub;
  logic [W:1]   A, B;
`ifdef ADDER72_PARITY_EN
  logic [2:0]   in_par_a = '0, in_par_b = '0, par_flip = '0;
  logic         par_err;
`endif

  adder72_in_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .B(B), .c0(c0), .out_sub(out_sub)
`ifdef ADDER72_PARITY_EN
    , .in_par_a(in_par_a), .in_par_b(in_par_b), .par_err(par_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit bp_rand = 1'b0;

  typedef struct { logic [W:1] a; logic [W:1] b; logic c; logic sub; } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W:1] rand72();
    logic [W:1] r;
    r[32:1]  = $urandom();
    r[64:33] = $urandom();
    r[72:65] = 8'($urandom());
    return r;
  endfunction

  // Reference: a 2-deep FIFO; ready while fewer than two held, valid while any held.
  initial forever begin
    bit   acc, drn;
    exp_t e;
    @(posedge clk or negedge rst_n);
    if (!rst_n) q.delete();
    else begin
      acc = in_valid && (q.size() < 2);
      drn = out_ready && (q.size() > 0);
      if (drn) void'(q.pop_front());
      if (acc) begin
        e.a   = in_a;
        e.b   = in_sub ? ~in_b : in_b;
        e.c   = in_sub ? 1'b1 : in_cin;
        e.sub = in_sub;
        q.push_back(e);
      end
    end
    #1;
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, q.size() < 2);
    if (q.size() != 0) begin
      chk("A", A, q[0].a);
      chk("B", B, q[0].b);
      chk("c0", c0, q[0].c);
      chk("out_sub", out_sub, q[0].sub);
    end
  end

  initial forever begin
    @(negedge clk);
    if (bp_rand) out_ready = 1'($urandom_range(0, 1));
  end

  // Present a request at a negedge and return at the negedge after it is accepted.
  task automatic send(input logic [W:1] a, input logic [W:1] b, input logic sub, input logic cin);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_cin = cin;
`ifdef ADDER72_PARITY_EN
    for (int k = 0; k < 3; k++) begin
      in_par_a[k] = ^a[k*24+1 +: 24];
      in_par_b[k] = ^b[k*24+1 +: 24] ^ par_flip[k];
    end
`endif
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed %0b, wanted 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W:1] r1, r2, r3, nb3;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_c0", c0, 0);
    chk("rst_out_sub", out_sub, 0);
    rst_n = 1'b1;

    // Add with carry across the lane-1/lane-2 boundary
    out_ready = 1'b1;
    @(negedge clk);
    send(72'h1, 72'hFFFFFF, 1'b0, 1'b0);
    chk("add_valid", out_valid, 1);
    chk("add_A", A, 72'h1);
    chk("add_B", B, 72'hFFFFFF);
    chk("add_c0", c0, 0);
    chk("add_sum", {1'b0, A} + {1'b0, B} + c0, 73'h1000000);

    // Subtract 5 - 3
    send(72'd5, 72'd3, 1'b1, 1'b0);
    nb3 = 72'd3;
    nb3 = ~nb3;
    chk("sub_B", B, nb3);
    chk("sub_c0", c0, 1);
    chk("sub_tag", out_sub, 1);
    chk("sub_result", {1'b0, A} + {1'b0, B} + c0, {1'b1, 72'd2});

    // Backpressure: two accepted, third stalls, then drains in order
    @(negedge clk);
    out_ready = 1'b0;
    r1 = rand72(); r2 = rand72(); r3 = rand72();
    send(r1, rand72(), 1'b0, 1'b1);
    send(r2, rand72(), 1'b0, 1'b0);
    chk("bp_in_ready_low", in_ready, 0);
    in_valid = 1'b1; in_a = r3; in_b = rand72(); in_sub = 1'b0; in_cin = 1'b0;
`ifdef ADDER72_PARITY_EN
    for (int k = 0; k < 3; k++) begin
      in_par_a[k] = ^in_a[k*24+1 +: 24];
      in_par_b[k] = ^in_b[k*24+1 +: 24];
    end
`endif
    repeat (3) @(negedge clk);
    chk("bp_stall", in_ready, 0);
    chk("bp_head_r1", A, r1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_head_r2", A, r2);
    chk("bp_ready_back", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_head_r3", A, r3);
    @(negedge clk);
    chk("bp_drained", out_valid, 0);

    // Streaming with random gaps, then with random backpressure
    for (int i = 0; i < 100; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(rand72(), rand72(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    bp_rand = 1'b1;
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      send(rand72(), rand72(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    bp_rand = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Asynchronous reset while two entries are held
    out_ready = 1'b0;
    send(rand72(), rand72(), 1'b0, 1'b0);
    send(rand72(), rand72(), 1'b1, 1'b0);
    chk("pre_rst_full", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ready", in_ready, 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_empty", out_valid, 0);

`ifdef ADDER72_PARITY_EN
    chk("par_clean", par_err, 0);
    par_flip = 3'b010;
    r1 = rand72();
    send(r1, rand72(), 1'b0, 1'b0);
    par_flip = 3'b000;
    chk("par_set", par_err, 1);
    chk("par_data", A, r1);
    send(rand72(), rand72(), 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("par_sticky", par_err, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
